// File: rtl/gaussian_stats_estimator.sv
// Block mean/variance estimator for a valid/ready stream of 2^7-quantized signed samples.
// Accumulates 2^LOG2_N samples, then derives mean (floor) and clamped variance.
module gaussian_stats_estimator #(
    parameter int unsigned LOG2_N = 10,
    parameter int unsigned W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [W-1:0]        sample_i,
    input  logic                sample_valid_i,
    output logic                sample_ready_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [W-1:0]        mean_o,
    output logic [2*W-1:0]      var_o,
    output logic [LOG2_N:0]     count_o
);

    localparam int unsigned SW = W + LOG2_N;
    localparam int unsigned QW = 2 * W + LOG2_N;
    localparam logic [LOG2_N:0] N_LAST = (LOG2_N + 1)'((1 << LOG2_N) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_CALC1,
        S_CALC2,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic signed [SW-1:0]   r_sum;
    logic [QW-1:0]          r_sum_sq;
    logic [LOG2_N:0]        r_count;
    logic signed [W-1:0]    r_mean;
    logic [2*W-1:0]         r_msq;

    logic                   w_accept;
    logic signed [SW-1:0]   w_sample_ext;
    logic signed [2*W-1:0]  w_sample_2w;
    logic signed [2*W-1:0]  w_prod;
    logic signed [2*W-1:0]  w_mean_2w;
    logic signed [2*W-1:0]  w_mean_sq;
    logic signed [2*W:0]    w_diff;
    logic [2*W-1:0]         w_var;

    assign w_accept     = (r_state == S_ACCUM) && sample_valid_i;
    assign w_sample_ext = {{LOG2_N{sample_i[W-1]}}, sample_i};
    assign w_sample_2w  = {{W{sample_i[W-1]}}, sample_i};
    assign w_prod       = w_sample_2w * w_sample_2w;
    assign w_mean_2w    = {{W{r_mean[W-1]}}, r_mean};
    assign w_mean_sq    = w_mean_2w * w_mean_2w;
    // Both squares are non-negative and below 2^(2W-1), so zero-extension is exact.
    assign w_diff       = $signed({1'b0, r_msq}) - $signed({1'b0, w_mean_sq});
    assign w_var        = w_diff[2*W] ? '0 : w_diff[2*W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next = S_ACCUM;
            S_ACCUM: if (w_accept && (r_count == N_LAST)) w_next = S_CALC1;
            S_CALC1: w_next = S_CALC2;
            S_CALC2: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum    <= '0;
            r_sum_sq <= '0;
            r_count  <= '0;
            r_mean   <= '0;
            r_msq    <= '0;
            mean_o   <= '0;
            var_o    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_sum    <= '0;
                        r_sum_sq <= '0;
                        r_count  <= '0;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_sum    <= r_sum + w_sample_ext;
                        r_sum_sq <= r_sum_sq + {{LOG2_N{1'b0}}, w_prod};
                        r_count  <= r_count + 1'b1;
                    end
                end
                S_CALC1: begin
                    r_mean <= W'(r_sum >>> LOG2_N);
                    r_msq  <= (2 * W)'(r_sum_sq >> LOG2_N);
                end
                S_CALC2: begin
                    // Outputs load on entry to DONE so they are valid while done_o is high.
                    mean_o <= r_mean;
                    var_o  <= w_var;
                end
                default: ;
            endcase
        end
    end

    assign sample_ready_o = (r_state == S_ACCUM);
    assign busy_o         = (r_state != S_IDLE);
    assign done_o         = (r_state == S_DONE);
    assign count_o        = r_count;

endmodule

// File: tb/tb_gaussian_stats_estimator.sv
// Directed bench: small-block estimator (N=4) plus a full-size instance (N=1024).
module tb_gaussian_stats_estimator;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Small instance, N = 4
    logic               a_start = 1'b0;
    logic signed [15:0] a_sample = '0;
    logic               a_valid = 1'b0;
    logic               a_ready, a_busy, a_done;
    logic signed [15:0] a_mean;
    logic [31:0]        a_var;
    logic [2:0]         a_count;

    // Full-size instance, N = 1024
    logic               b_start = 1'b0;
    logic signed [15:0] b_sample = '0;
    logic               b_valid = 1'b0;
    logic               b_ready, b_busy, b_done;
    logic signed [15:0] b_mean;
    logic [31:0]        b_var;
    logic [10:0]        b_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gaussian_stats_estimator #(.LOG2_N(2), .W(16)) u_dut_a (
        .clk(clk), .rst(rst), .start_i(a_start), .sample_i(a_sample),
        .sample_valid_i(a_valid), .sample_ready_o(a_ready), .busy_o(a_busy),
        .done_o(a_done), .mean_o(a_mean), .var_o(a_var), .count_o(a_count)
    );

    gaussian_stats_estimator #(.LOG2_N(10), .W(16)) u_dut_b (
        .clk(clk), .rst(rst), .start_i(b_start), .sample_i(b_sample),
        .sample_valid_i(b_valid), .sample_ready_o(b_ready), .busy_o(b_busy),
        .done_o(b_done), .mean_o(b_mean), .var_o(b_var), .count_o(b_count)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input bit big);
        @(negedge clk);
        if (big) b_start = 1'b1; else a_start = 1'b1;
        @(negedge clk);
        if (big) b_start = 1'b0; else a_start = 1'b0;
    endtask

    // Presents one sample after 'gap' idle cycles and returns after the accepting edge.
    task automatic send(input bit big, input logic signed [15:0] s, input int gap);
        int t = 0;
        repeat (gap) begin
            @(negedge clk);
            if (big) b_valid = 1'b0; else a_valid = 1'b0;
        end
        @(negedge clk);
        if (big) begin b_valid = 1'b1; b_sample = s; end
        else     begin a_valid = 1'b1; a_sample = s; end
        while (!(big ? b_ready : a_ready) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!(big ? b_ready : a_ready)) check("ready_timeout", 0, 1);
        @(posedge clk);
    endtask

    // Counts falling edges from the last accept until done_o is seen.
    task automatic wait_done(input bit big, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            if (big) b_valid = 1'b0; else a_valid = 1'b0;
            lat++;
        end while (!(big ? b_done : a_done) && lat < 40);
        if (!(big ? b_done : a_done)) check("done_timeout", 0, 1);
    endtask

    task automatic block_a(input logic signed [15:0] s0, input logic signed [15:0] s1,
                           input logic signed [15:0] s2, input logic signed [15:0] s3,
                           input int gap, output int lat);
        pulse_start(1'b0);
        send(1'b0, s0, 0);
        send(1'b0, s1, gap);
        send(1'b0, s2, gap);
        send(1'b0, s3, gap);
        wait_done(1'b0, lat);
    endtask

    initial begin
        int lat;
        int acc_cnt;

        repeat (3) @(negedge clk);
        check("rst_mean", a_mean, 0);
        check("rst_var", a_var, 0);
        check("rst_busy", a_busy, 0);
        check("rst_ready", a_ready, 0);
        check("rst_done", a_done, 0);
        check("rst_count", a_count, 0);
        rst = 1'b1;

        // 1: constant 128, valid held high
        block_a(128, 128, 128, 128, 0, lat);
        check("t1_latency", lat, 3);
        check("t1_mean", a_mean, 128);
        check("t1_var", a_var, 0);
        check("t1_count", a_count, 4);
        check("t1_busy_done", a_busy, 1);
        @(negedge clk);
        check("t1_done_pulse", a_done, 0);
        check("t1_idle_busy", a_busy, 0);
        check("t1_count_hold", a_count, 4);
        check("t1_mean_hold", a_mean, 128);

        // 2: +/-100 with two-cycle valid gaps
        acc_cnt = 0;
        fork
            forever begin
                @(posedge clk);
                if (a_valid && a_ready) acc_cnt++;
            end
        join_none
        block_a(100, -100, 100, -100, 2, lat);
        disable fork;
        check("t2_accepts", acc_cnt, 4);
        check("t2_latency", lat, 3);
        check("t2_mean", a_mean, 0);
        check("t2_var", a_var, 10000);

        // 3: floor mean and negative-diff clamp
        block_a(-1, -1, -1, -2, 0, lat);
        check("t3_mean", a_mean, -2);
        check("t3_var", a_var, 0);

        // 4: most-negative samples
        block_a(-32768, -32768, -32768, -32768, 1, lat);
        check("t4_mean", a_mean, -32768);
        check("t4_var", a_var, 0);

        // 5: start ignored in ACCUM, then reset mid-block
        pulse_start(1'b0);
        check("t5_count_clr", a_count, 0);
        send(1'b0, 7, 0);
        send(1'b0, 9, 0);
        @(negedge clk);
        a_valid = 1'b0;
        pulse_start(1'b0);
        check("t5_count_kept", a_count, 2);
        check("t5_still_accum", a_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_rst_mean", a_mean, 0);
        check("t5_rst_var", a_var, 0);
        check("t5_rst_count", a_count, 0);
        check("t5_rst_busy", a_busy, 0);
        check("t5_rst_ready", a_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        block_a(10, 10, 10, 10, 0, lat);
        check("t5_mean", a_mean, 10);
        check("t5_var", a_var, 0);

        // 6: N=1024, alternating +/-128 -> mean 0, var 16384
        pulse_start(1'b1);
        for (int i = 0; i < 1024; i++) send(1'b1, (i % 2 == 0) ? 16'sd128 : -16'sd128, 0);
        wait_done(1'b1, lat);
        check("t6_latency", lat, 3);
        check("t6_mean", b_mean, 0);
        check("t6_var", b_var, 16384);
        check("t6_count", b_count, 1024);

        // 6b: alternating 256/0 -> mean 128, var 16384; prior results hold meanwhile
        pulse_start(1'b1);
        for (int i = 0; i < 512; i++) send(1'b1, (i % 2 == 0) ? 16'sd256 : 16'sd0, 0);
        #1;
        check("t6_mid_count", b_count, 512);
        check("t6_hold_mean", b_mean, 0);
        check("t6_hold_var", b_var, 16384);
        for (int i = 512; i < 1024; i++) send(1'b1, (i % 2 == 0) ? 16'sd256 : 16'sd0, 0);
        wait_done(1'b1, lat);
        check("t6b_mean", b_mean, 128);
        check("t6b_var", b_var, 16384);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
